// File: rtl/rv32m_pkg.sv
// Shared RV32M execute-cluster definitions for the pipelined multiplier.
//   mul_op_e     funct3[1:0] encoding of MUL/MULH/MULHSU/MULHU
//   mul_stage_t  one pipeline stage: partial accumulator, operand magnitudes,
//                product sign, high-half select, ROB tag and valid
//   MUL_STAGES   number of radix-8 accumulate stages
package rv32m_pkg;

  localparam int unsigned MUL_WIDTH     = 32;
  localparam int unsigned MUL_TAG_WIDTH = 5;
  localparam int unsigned MUL_STAGES    = (MUL_WIDTH + 2) / 3;

  typedef enum logic [1:0] {
    OpMul    = 2'b00,
    OpMulh   = 2'b01,
    OpMulhsu = 2'b10,
    OpMulhu  = 2'b11
  } mul_op_e;

  typedef struct packed {
    logic [2*MUL_WIDTH-1:0]   acc;
    logic [MUL_WIDTH-1:0]     mag_a;
    logic [MUL_WIDTH-1:0]     mag_b;
    logic                     sign_p;
    logic                     hi_sel;
    logic [MUL_TAG_WIDTH-1:0] tag;
    logic                     valid;
  } mul_stage_t;

endpackage

// File: rtl/radix8_mul_stage.sv
// One combinational radix-8 accumulate step.
//   stage_in   stage contents entering step IDX
//   stage_out  same contents with acc += (mag_a * digit) << 3*(IDX-1)
// IDX is the 1-based stage index selecting the 3-bit multiplier digit.
module radix8_mul_stage
  import rv32m_pkg::*;
#(
  parameter int unsigned IDX = 1
) (
  input  mul_stage_t stage_in,
  output mul_stage_t stage_out
);

  localparam int unsigned Shift = 3 * (IDX - 1);

  // Zero-fill above the operand so the top digit reads only real bits.
  logic [MUL_WIDTH+2:0]   b_ext;
  logic [2:0]             digit;
  logic [2*MUL_WIDTH-1:0] partial;

  always_comb begin
    b_ext   = {3'b000, stage_in.mag_b};
    digit   = b_ext[Shift +: 3];
    partial = ((2*MUL_WIDTH)'(stage_in.mag_a) * (2*MUL_WIDTH)'(digit)) << Shift;

    stage_out     = stage_in;
    stage_out.acc = stage_in.acc + partial;
  end

endmodule

// File: rtl/radix8_multiplier.sv
// Pipelined radix-8 integer multiplier (MUL/MULH/MULHSU/MULHU).
//   clk, rst          clock; asynchronous active-high reset
//   flush             synchronous kill of every in-flight op and the current input
//   valid_in, op      op present this cycle and its funct3[1:0] encoding
//   src_a, src_b      multiplicand (rs1) and multiplier (rs2)
//   tag_in            ROB tag travelling with the op
//   valid_out         result valid, 12 cycles after issue, one op per cycle
//   result, tag_out   selected product half and its tag; zero when not valid
// WIDTH/TAG_WIDTH must match the rv32m_pkg stage struct.
module radix8_multiplier
  import rv32m_pkg::*;
#(
  parameter int unsigned WIDTH     = MUL_WIDTH,
  parameter int unsigned TAG_WIDTH = MUL_TAG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 valid_in,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     src_a,
  input  logic [WIDTH-1:0]     src_b,
  input  logic [TAG_WIDTH-1:0] tag_in,
  output logic                 valid_out,
  output logic [WIDTH-1:0]     result,
  output logic [TAG_WIDTH-1:0] tag_out
);

  mul_stage_t pipe_q   [MUL_STAGES+1];
  mul_stage_t stage_nxt[MUL_STAGES+1];
  mul_stage_t in_d;

  mul_op_e    op_e;
  logic       sign_a;
  logic       sign_b;

  // Input conditioning: signed operands become sign + magnitude so the
  // accumulate stages only ever add unsigned partial products.
  always_comb begin
    op_e   = mul_op_e'(op);
    sign_a = ((op_e == OpMulh) || (op_e == OpMulhsu)) && src_a[WIDTH-1];
    sign_b = (op_e == OpMulh) && src_b[WIDTH-1];

    in_d = '0;
    // Idle or flushed inputs load an all-zero bubble, keeping X and toggling out.
    if (valid_in && !flush) begin
      in_d.mag_a  = sign_a ? (~src_a + 1'b1) : src_a;
      in_d.mag_b  = sign_b ? (~src_b + 1'b1) : src_b;
      in_d.sign_p = sign_a ^ sign_b;
      in_d.hi_sel = (op_e != OpMul);
      in_d.tag    = tag_in;
      in_d.valid  = 1'b1;
    end
  end

  assign stage_nxt[0] = '0;

  for (genvar k = 1; k <= MUL_STAGES; k++) begin : g_stage
    radix8_mul_stage #(
      .IDX (k)
    ) u_stage (
      .stage_in  (pipe_q[k-1]),
      .stage_out (stage_nxt[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= MUL_STAGES; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      pipe_q[0] <= in_d;
      for (int k = 1; k <= MUL_STAGES; k++) begin
        pipe_q[k] <= flush ? '0 : stage_nxt[k];
      end
    end
  end

  mul_stage_t             last;
  logic [2*WIDTH-1:0]     prod;

  always_comb begin
    last      = pipe_q[MUL_STAGES];
    prod      = last.sign_p ? (~last.acc + 1'b1) : last.acc;
    valid_out = last.valid;
    result    = '0;
    tag_out   = '0;
    if (last.valid) begin
      result  = last.hi_sel ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
      tag_out = last.tag;
    end
  end

endmodule

// File: tb/tb_radix8_multiplier.sv
// Self-checking bench for radix8_multiplier: directed corner cases followed by
// randomized traffic with bubbles and flushes, checked every cycle against a
// plain-arithmetic reference product and a per-cycle expectation schedule.
module tb_radix8_multiplier;

  localparam int Lat  = 12;
  localparam int MaxC = 40000;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        valid_in;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  tag_in;
  logic        valid_out;
  logic [31:0] result;
  logic [4:0]  tag_out;

  radix8_multiplier dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .valid_in  (valid_in),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .tag_in    (tag_in),
    .valid_out (valid_out),
    .result    (result),
    .tag_out   (tag_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  bit          exp_v [MaxC];
  logic [31:0] exp_r [MaxC];
  logic [4:0]  exp_t [MaxC];

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] req);
    n_chk++;
    if (obs === req) n_pass++;
    else $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, obs, req);
  endtask

  // Reference: exact product of the sign/zero-extended operands.
  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [65:0] ae, be, p;
    ae = (o == 2'b01 || o == 2'b10) ? {{34{a[31]}}, a} : {34'b0, a};
    be = (o == 2'b01)               ? {{34{b[31]}}, b} : {34'b0, b};
    p  = ae * be;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // One cycle: check outputs against the schedule, then drive this cycle's input.
  task automatic step(input logic v, input logic [1:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] t, input logic fl,
                      input logic use_k, input logic [31:0] k);
    @(posedge clk);
    #1;
    cyc++;
    check("x_out", 64'($isunknown({valid_out, result, tag_out})), 64'd0);
    check("valid", 64'(valid_out), 64'(exp_v[cyc]));
    check("result", 64'(result), exp_v[cyc] ? 64'(exp_r[cyc]) : 64'd0);
    check("tag", 64'(tag_out), exp_v[cyc] ? 64'(exp_t[cyc]) : 64'd0);
    valid_in = v;
    flush    = fl;
    if (v) begin
      op = o; src_a = a; src_b = b; tag_in = t;
    end else begin
      op = 'x; src_a = 'x; src_b = 'x; tag_in = 'x;
    end
    if (fl) begin
      for (int i = 1; i <= Lat; i++) exp_v[cyc+i] = 1'b0;
    end else if (v) begin
      exp_v[cyc+Lat] = 1'b1;
      exp_r[cyc+Lat] = use_k ? k : ref_mul(o, a, b);
      exp_t[cyc+Lat] = t;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic issue_k(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, input logic [31:0] k);
    step(1'b1, o, a, b, t, 1'b0, 1'b1, k);
  endtask

  initial begin
    int ops;
    int guard;
    rst = 1'b1; flush = 1'b0; valid_in = 1'b0;
    op = '0; src_a = '0; src_b = '0; tag_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_tag", 64'(tag_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic op, fixed expectation; lone valid cycle is enforced by the schedule.
    issue_k(2'b00, 32'd7, 32'd6, 5'd3, 32'd42);
    idle(Lat + 2);

    // Sign corners.
    issue_k(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE);
    issue_k(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000);
    issue_k(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF);
    issue_k(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000);
    issue_k(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 32'h8000_0000);
    issue_k(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000);
    idle(Lat + 2);

    // Back-to-back, tags 0..11.
    for (int i = 0; i < 12; i++)
      step(1'b1, 2'($urandom), $urandom, $urandom, 5'(i), 1'b0, 1'b0, 32'd0);
    idle(Lat + 2);

    // Flush with five in flight and valid_in on the flush cycle, then a fresh op.
    for (int i = 0; i < 5; i++)
      step(1'b1, 2'($urandom), $urandom, $urandom, 5'(20 + i), 1'b0, 1'b0, 32'd0);
    step(1'b1, 2'b00, 32'd3, 32'd3, 5'd30, 1'b1, 1'b0, 32'd0);
    issue_k(2'b00, 32'd5, 32'd9, 5'd31, 32'd45);
    idle(Lat + 2);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 8; i++)
      step(1'b1, 2'($urandom), $urandom, $urandom, 5'(i), 1'b0, 1'b0, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(valid_out), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    check("arst_tag", 64'(tag_out), 64'd0);
    valid_in = 1'b0;
    for (int i = 1; i <= Lat + 1; i++) exp_v[cyc+i] = 1'b0;
    @(posedge clk);
    #4;
    rst = 1'b0;
    idle(Lat + 2);

    // Random traffic with bubbles and occasional flush.
    ops   = 0;
    guard = 0;
    while (ops < 10000 && guard < 30000) begin
      logic v, fl;
      v  = 1'($urandom);
      fl = ($urandom_range(0, 99) == 0);
      if (v) ops++;
      guard++;
      step(v, 2'($urandom), $urandom, $urandom, 5'($urandom), fl, 1'b0, 32'd0);
    end
    check("rand_budget", 64'(ops >= 10000), 64'd1);
    idle(Lat + 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
